// File: rtl/lru_lookup_scheduler_if.sv
// Handshake bundle between the lookup scheduler, its requesters and the cache frontend.
// master = requester/cache side, slave = scheduler side.
interface lru_lookup_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int TAGS_WIDTH = 48,
  parameter int DATA_WIDTH = 512
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*TAGS_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_err;
  logic                          cache_addr_valid;
  logic                          cache_addr_ready;
  logic [TAGS_WIDTH-1:0]         cache_addr_data;
  logic                          cache_data_valid;
  logic                          cache_data_ready;
  logic [DATA_WIDTH-1:0]         cache_data_data;

  modport master (
    output req_valid, req_addr, rsp_ready, cache_addr_ready, cache_data_valid, cache_data_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, cache_addr_valid, cache_addr_data, cache_data_ready
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, cache_addr_ready, cache_data_valid, cache_data_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, cache_addr_valid, cache_addr_data, cache_data_ready
  );
endinterface

// File: rtl/lru_lookup_scheduler.sv
// Round-robin scheduler sharing one cache lookup port between NUM_REQ requesters, one lookup in flight.
// Optional WAIT watchdog with DRAIN of the late beat: define LOOKUP_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for a request; grants round-robin from rr_ptr
// ISSUE   | presenting latched address to the cache
// WAIT    | waiting for the cache line
// RESP    | presenting response to the granted requester
// DRAIN   | (timeout build) discarding the late cache beat of an aborted lookup
module lru_lookup_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TAGS_WIDTH     = 48,
  parameter int DATA_WIDTH     = 512,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rstn,
  lru_lookup_scheduler_if.slave  bus,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3
`ifdef LOOKUP_TIMEOUT_EN
    , S_DRAIN = 3'd4
`endif
  } state_t;

  state_t                 state, state_nxt;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        gnt_idx;
  logic                   gnt_found;
  logic [TAGS_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   tmo_hit;
  logic                   err_resp;

  // search upward from rr_ptr, wrapping at NUM_REQ
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

`ifdef LOOKUP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  // a beat arriving in the timeout cycle wins over the abort
  assign tmo_hit  = (state == S_WAIT) && !bus.cache_data_valid &&
                    (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign err_resp = err_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_ISSUE && bus.cache_addr_ready)
        tmo_cnt <= '0;
      else if (state == S_WAIT && !bus.cache_data_valid)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (state == S_WAIT && bus.cache_data_valid)
        err_q <= 1'b0;
      else if (tmo_hit)
        err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign err_resp = 1'b0;
`endif

  assign bus.rsp_err         = err_resp;
  assign bus.rsp_data        = data_q;
  assign bus.cache_addr_data = addr_q;

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (gnt_found) state_nxt = S_ISSUE;
      S_ISSUE: if (bus.cache_addr_ready) state_nxt = S_WAIT;
      S_WAIT:  if (bus.cache_data_valid || tmo_hit) state_nxt = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready[grant_id]) begin
`ifdef LOOKUP_TIMEOUT_EN
          state_nxt = err_resp ? S_DRAIN : S_IDLE;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
`ifdef LOOKUP_TIMEOUT_EN
      S_DRAIN: if (bus.cache_data_valid) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready        = '0;
    bus.rsp_valid        = '0;
    bus.cache_addr_valid = 1'b0;
    bus.cache_data_ready = 1'b0;
    busy                 = (state != S_IDLE);
    case (state)
      S_IDLE:  if (gnt_found) bus.req_ready[gnt_idx] = 1'b1;
      S_ISSUE: bus.cache_addr_valid = 1'b1;
      S_WAIT:  bus.cache_data_ready = 1'b1;
      S_RESP:  bus.rsp_valid[grant_id] = 1'b1;
`ifdef LOOKUP_TIMEOUT_EN
      S_DRAIN: bus.cache_data_ready = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr   <= '0;
      grant_id <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      if (state == S_IDLE && gnt_found) begin
        grant_id <= gnt_idx;
        addr_q   <= bus.req_addr[int'(gnt_idx)*TAGS_WIDTH +: TAGS_WIDTH];
      end
      if (state == S_WAIT && bus.cache_data_valid)
        data_q <= bus.cache_data_data;
      else if (tmo_hit)
        data_q <= '0;
      if (state == S_RESP && bus.rsp_ready[grant_id])
        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: tb/tb_lru_lookup_scheduler.sv
// Scoreboard bench for lru_lookup_scheduler: behavioural requesters and cache, expected responses queued at grant.
// Timeout/DRAIN scenario runs when LOOKUP_TIMEOUT_EN is defined.
module tb_lru_lookup_scheduler;
  localparam int NR = 4;
  localparam int TW = 48;
  localparam int DW = 512;
  localparam int IW = $clog2(NR);

  typedef struct {
    int            id;
    logic [TW-1:0] addr;
    logic          err;
    int            t_req;
  } sb_t;

  logic          clk;
  logic          rstn;
  logic          busy;
  logic [IW-1:0] grant_id;

  lru_lookup_scheduler_if #(.NUM_REQ(NR), .TAGS_WIDTH(TW), .DATA_WIDTH(DW)) bus ();

  lru_lookup_scheduler #(
    .NUM_REQ(NR), .TAGS_WIDTH(TW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            req_cnt [NR];
  logic [TW-1:0] tb_addr [NR];
  sb_t           sb_q [$];
  logic [TW-1:0] cache_q [$];
  int            exp_rr = 0;
  int            addr_stall = 0;
  int            rsp_stall = 0;
  bit            cache_silent = 0;
  bit            pat_mode = 0;
  int            exp_lat = 0;
  bit            rsp_seen = 0;
  bit            chk_tput = 0;
  bit            have_last = 0;
  int            last_gnt = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] line_of(input logic [TW-1:0] a);
    logic [DW-1:0] p;
    p = {(DW/8){8'hA5}};
    if (pat_mode) p = p ^ DW'(a) ^ (DW'(a) << 200);
    return p;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NR; i++) s += req_cnt[i];
    return s;
  endfunction

  // behavioural requesters, cache and response sink; all handshakes observed just after the falling edge
  always begin
    logic [NR-1:0] oh;
    int            exp_g;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]         = (req_cnt[i] != 0);
      bus.req_addr[i*TW +: TW] = tb_addr[i];
    end
    if (bus.cache_addr_valid && addr_stall > 0) begin
      bus.cache_addr_ready = 1'b0;
      addr_stall--;
    end else bus.cache_addr_ready = 1'b1;
    bus.cache_data_valid = (cache_q.size() != 0) && !cache_silent;
    bus.cache_data_data  = (cache_q.size() != 0) ? line_of(cache_q[0]) : '0;
    if (bus.rsp_valid != '0 && rsp_stall > 0) begin
      bus.rsp_ready = ~bus.rsp_valid;
      rsp_stall--;
    end else bus.rsp_ready = '1;
    #1;
    if (rstn) begin
      if (busy) check_val("req_ready_busy", DW'(bus.req_ready), '0);
      else begin
        check_val("data_ready_idle", DW'(bus.cache_data_ready), '0);
        if (bus.req_valid != '0) begin
          exp_g = -1;
          for (int k = 0; k < NR; k++)
            if (exp_g < 0 && bus.req_valid[(exp_rr + k) % NR]) exp_g = (exp_rr + k) % NR;
          oh = '0;
          oh[exp_g] = 1'b1;
          check_val("req_grant", DW'(bus.req_ready), DW'(oh));
          if (chk_tput && have_last) check_val("throughput", DW'(cyc - last_gnt), DW'(4));
          have_last = 1;
          last_gnt  = cyc;
          sb_q.push_back('{exp_g, tb_addr[exp_g], cache_silent, cyc});
          req_cnt[exp_g]--;
          tb_addr[exp_g] += 48'h1000;
        end else check_val("req_ready_novalid", DW'(bus.req_ready), '0);
      end
      if (bus.cache_addr_valid) begin
        check_val("one_outstanding", DW'(cache_q.size()), '0);
        check_val("cache_addr", DW'(bus.cache_addr_data), (sb_q.size() != 0) ? DW'(sb_q[0].addr) : '0);
        if (bus.cache_addr_ready) cache_q.push_back(bus.cache_addr_data);
      end
      if (bus.cache_data_valid && bus.cache_data_ready) void'(cache_q.pop_front());
      if (bus.rsp_valid != '0) begin
        if (sb_q.size() == 0) check_val("rsp_unexpected", DW'(bus.rsp_valid), '0);
        else begin
          oh = '0;
          oh[sb_q[0].id] = 1'b1;
          if (!rsp_seen) begin
            rsp_seen = 1;
            if (exp_lat != 0) check_val("latency", DW'(cyc - sb_q[0].t_req), DW'(exp_lat));
          end
          check_val("rsp_valid", DW'(bus.rsp_valid), DW'(oh));
          check_val("grant_id", DW'(grant_id), DW'(sb_q[0].id));
          check_val("rsp_data", bus.rsp_data, sb_q[0].err ? '0 : line_of(sb_q[0].addr));
          check_val("rsp_err", DW'(bus.rsp_err), DW'(sb_q[0].err));
          if (bus.rsp_ready[sb_q[0].id]) begin
            exp_rr   = (sb_q[0].id + 1) % NR;
            rsp_seen = 0;
            void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!(sb_q.size() == 0 && pending() == 0 && cache_q.size() == 0 && !busy) && n < max_cyc);
    check_val("idle_reached", DW'(sb_q.size() + pending() + cache_q.size() + int'(busy)), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < NR; i++) begin
      req_cnt[i] = 0;
      tb_addr[i] = TW'(48'h0000_0100_0000 * (i + 1));
    end
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #2;
    check_val("rst_busy", DW'(busy), '0);
    check_val("rst_grant_id", DW'(grant_id), '0);
    check_val("rst_rsp_valid", DW'(bus.rsp_valid), '0);
    check_val("rst_rsp_data", bus.rsp_data, '0);
    check_val("rst_rsp_err", DW'(bus.rsp_err), '0);
    check_val("rst_cache_addr_valid", DW'(bus.cache_addr_valid), '0);
    check_val("rst_req_ready", DW'(bus.req_ready), '0);

    // single lookup from requester 1, minimum latency, A5 line
    @(negedge clk);
    pat_mode   = 0;
    tb_addr[1] = 48'h0000_1234_5678;
    exp_lat    = 3;
    req_cnt[1] = 1;
    wait_idle(50);

    // bring rr_ptr to 0, then five back-to-back lookups with all requesters pending
    pat_mode   = 1;
    exp_lat    = 0;
    req_cnt[3] = 1;
    wait_idle(50);
    have_last = 0;
    chk_tput  = 1;
    exp_lat   = 3;
    req_cnt[0] = 2; req_cnt[1] = 1; req_cnt[2] = 1; req_cnt[3] = 1;
    wait_idle(100);
    chk_tput = 0;
    exp_lat  = 0;

    // stalled cache address and response; a second request must wait its turn
    addr_stall = 5;
    rsp_stall  = 3;
    req_cnt[2] = 1;
    @(negedge clk);
    req_cnt[0] = 1;
    wait_idle(100);

    // random traffic with random stalls
    for (int it = 0; it < 24; it++) begin
      req_cnt[$urandom_range(0, NR-1)] += 1;
      if ($urandom_range(0, 1) == 1) req_cnt[$urandom_range(0, NR-1)] += 1;
      addr_stall = $urandom_range(0, 3);
      rsp_stall  = $urandom_range(0, 3);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    wait_idle(1000);

`ifdef LOOKUP_TIMEOUT_EN
    // silent cache: abort after 16 WAIT cycles, late beat drained, then a clean lookup
    cache_silent = 1;
    exp_lat      = 18;
    req_cnt[0]   = 1;
    n = 0;
    do begin @(negedge clk); #2; n++; end while ((sb_q.size() != 0 || pending() != 0) && n < 60);
    check_val("timeout_rsp_done", DW'(sb_q.size() + pending()), '0);
    @(negedge clk);
    #2;
    check_val("drain_busy", DW'(busy), DW'(1));
    check_val("drain_data_ready", DW'(bus.cache_data_ready), DW'(1));
    cache_silent = 0;
    wait_idle(50);
    exp_lat    = 3;
    req_cnt[1] = 1;
    wait_idle(50);
    exp_lat = 0;
`endif

    // reset while waiting on the cache abandons the lookup
    cache_silent = 1;
    req_cnt[2]   = 1;
    n = 0;
    do begin @(negedge clk); #2; n++; end while (cache_q.size() == 0 && n < 50);
    check_val("wait_entered", DW'(cache_q.size()), DW'(1));
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    sb_q.delete();
    cache_q.delete();
    for (int i = 0; i < NR; i++) req_cnt[i] = 0;
    exp_rr       = 0;
    rsp_seen     = 0;
    cache_silent = 0;
    @(negedge clk);
    rstn = 1'b1;
    #2;
    check_val("midrst_busy", DW'(busy), '0);
    check_val("midrst_rsp_valid", DW'(bus.rsp_valid), '0);
    check_val("midrst_grant_id", DW'(grant_id), '0);
    req_cnt[0] = 1; req_cnt[1] = 1; req_cnt[2] = 1; req_cnt[3] = 1;
    wait_idle(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/lru_lookup_scheduler.md
LRU_LOOKUP_SCHEDULER -- requirements
Module: lru_lookup_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one cache lookup port (range 2..16).
REQ-002 SHALL have parameter TAGS_WIDTH, default 48: lookup address/tag width.
REQ-003 SHALL have parameter DATA_WIDTH, default 512: cache line width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024: watchdog limit in WAIT; only used when LOOKUP_TIMEOUT_EN is defined.
REQ-005 SHALL have ports:
 - clk  in  1  clock; all logic on rising edge.
 - rstn  in  1  reset, synchronous, active-low.
 - req_valid  in  NUM_REQ  per-requester lookup request.
 - req_addr  in  NUM_REQ*TAGS_WIDTH  packed addresses; requester i at [i*TAGS_WIDTH +: TAGS_WIDTH].
 - req_ready  out  NUM_REQ  one-hot accept.
 - rsp_valid  out  NUM_REQ  one-hot response valid.
 - rsp_ready  in  NUM_REQ  per-requester response accept.
 - rsp_data  out  DATA_WIDTH  returned line.
 - rsp_err  out  1  response is a timeout abort.
 - cache_addr_valid  out  1  lookup to cache frontend.
 - cache_addr_ready  in  1  cache accepts lookup.
 - cache_addr_data  out  TAGS_WIDTH  lookup address.
 - cache_data_valid  in  1  cache returns line.
 - cache_data_ready  out  1  scheduler accepts line.
 - cache_data_data  in  DATA_WIDTH  returned line.
 - busy  out  1  state != IDLE.
 - grant_id  out  clog2(NUM_REQ)  requester currently owning the port.

Function
REQ-006 SHALL serialise lookups: at most one outstanding cache lookup at any time.
REQ-007 SHALL run FSM IDLE, ISSUE, WAIT, RESP (plus DRAIN when LOOKUP_TIMEOUT_EN).
REQ-008 IDLE: if any req_valid, SHALL grant round-robin, searching upward from rr_ptr with wrap at NUM_REQ; assert req_ready[grant] that same cycle (combinational); latch address and grant_id; next state ISSUE.
REQ-009 req_ready SHALL be 0 in all states other than IDLE and 0 in IDLE with no req_valid.
REQ-010 ISSUE: cache_addr_valid=1 with latched address, held stable until cache_addr_ready; on handshake -> WAIT.
REQ-011 WAIT: cache_data_ready=1; on cache_data_valid capture cache_data_data into rsp_data, rsp_err=0 -> RESP.
REQ-012 cache_data_ready SHALL be 0 outside WAIT and DRAIN; cache_data_valid outside those states is ignored.
REQ-013 RESP: rsp_valid[grant_id]=1, rsp_data/rsp_err stable until rsp_ready[grant_id]; on handshake rr_ptr <= (grant_id+1) mod NUM_REQ, -> IDLE (or DRAIN, REQ-019).
REQ-014 Minimum latency, all ready signals high: req handshake cycle 0, cache_addr handshake cycle 1, cache_data in cycle 2, rsp_valid cycle 3; back-to-back throughput one lookup per 4 cycles.
REQ-015 rsp_ready on a non-granted requester SHALL have no effect.
REQ-016 Requester dropping req_valid after grant SHALL not cancel the lookup; response still delivered.
REQ-017 rr_ptr SHALL only advance on response handshake; requests arriving in non-IDLE states wait.

Reset
REQ-018 With rstn=0 at a clock edge: state=IDLE, rr_ptr=0, grant_id=0, rsp_data=0, rsp_err=0, timeout counter=0; all valid/ready outputs 0 and busy=0 while in IDLE after reset; reset mid-lookup abandons it without any response.

Configuration
REQ-019 Macro LOOKUP_TIMEOUT_EN defined: counter clears on entry to WAIT, increments each WAIT cycle without cache_data_valid; on reaching TIMEOUT_CYCLES -> RESP with rsp_data=0, rsp_err=1; after that response handshake -> DRAIN (cache_data_ready=1, busy=1) until one cache_data beat is discarded, then IDLE; cache_data_valid in same cycle as timeout SHALL win (normal response).
REQ-020 Macro undefined: no counter, no DRAIN state, rsp_err tied 0, WAIT unbounded.

Verification
REQ-021 Single req 1 addr 0x0000_1234_5678, all readies 1, cache returns 0xA5 pattern -> rsp_valid=4'b0010 at cycle 3, rsp_data=0xA5 pattern, rsp_err=0.
REQ-022 req_valid=4'b1111 held, rr_ptr=0 -> grant order 0,1,2,3,0 across five lookups, each grant_id matching rsp_valid bit.
REQ-023 cache_addr_ready low 5 cycles, rsp_ready low 3 cycles -> cache_addr_data and rsp_data stable throughout, no second cache_addr_valid.
REQ-024 LOOKUP_TIMEOUT_EN, TIMEOUT_CYCLES=16, cache silent -> rsp_err=1, rsp_data=0 after 16 WAIT cycles; later cache beat consumed in DRAIN, next lookup returns correct data.
REQ-025 rstn=0 for 1 cycle during WAIT -> busy=0, all rsp_valid=0, next grant to requester 0.
